// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one command at a time to an external ALU and
// returns its result through a valid/ready response port.
// Ports: CLK, RESET (async, active high); CMD_VALID/CMD_READY with
//   CMD_OP/CMD_A/CMD_B; ALU_IN_A/ALU_IN_B/ALU_Op_Code to the ALU and
//   ALU_Out back; RES_VALID/RES_READY with RES_DATA/RES_ERR; BUSY.
// Parameter ALU_LATENCY (1..4): cycles from operand drive to ALU_Out.
// Macro ALU_ISSUE_OPCHECK_EN: opcodes 0xC..0xE are rejected with RES_ERR.
module alu_issue_ctrl #(
  parameter int ALU_LATENCY = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [3:0] CMD_OP,
  input  logic [7:0] CMD_A,
  input  logic [7:0] CMD_B,
  output logic [7:0] ALU_IN_A,
  output logic [7:0] ALU_IN_B,
  output logic [3:0] ALU_Op_Code,
  input  logic [7:0] ALU_Out,
  output logic       RES_VALID,
  input  logic       RES_READY,
  output logic [7:0] RES_DATA,
  output logic       RES_ERR,
  output logic       BUSY
);

  localparam logic [3:0] OP_NOP = 4'hF;
  localparam logic [1:0] CNT_LOAD = 2'(ALU_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t     state, state_n;
  logic [1:0] cnt, cnt_n;
  logic [7:0] a_q, a_n;
  logic [7:0] b_q, b_n;
  logic [3:0] op_q, op_n;
  logic [7:0] res_q, res_n;
  logic       vld_q, vld_n;
  logic       err_q, err_n;
  logic       bad_op;

`ifdef ALU_ISSUE_OPCHECK_EN
  assign bad_op = (CMD_OP == 4'hC) ||
                  (CMD_OP == 4'hD) ||
                  (CMD_OP == 4'hE);
`else
  assign bad_op = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= 2'd0;
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      op_q  <= OP_NOP;
      res_q <= 8'h00;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      a_q   <= a_n;
      b_q   <= b_n;
      op_q  <= op_n;
      res_q <= res_n;
      vld_q <= vld_n;
      err_q <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    a_n     = a_q;
    b_n     = b_q;
    op_n    = op_q;
    res_n   = res_q;
    vld_n   = vld_q;
    err_n   = err_q;
    unique case (state)
      IDLE: begin
        if (CMD_VALID) begin
          if (bad_op) begin
            // Rejected opcode never reaches the ALU.
            res_n   = 8'h00;
            err_n   = 1'b1;
            vld_n   = 1'b1;
            state_n = RESP;
          end else begin
            a_n     = CMD_A;
            b_n     = CMD_B;
            op_n    = CMD_OP;
            cnt_n   = CNT_LOAD;
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 2'd0) begin
          res_n   = ALU_Out;
          err_n   = 1'b0;
          vld_n   = 1'b1;
          op_n    = OP_NOP;
          state_n = RESP;
        end else begin
          cnt_n = cnt - 2'd1;
        end
      end
      RESP: begin
        if (RES_READY) begin
          vld_n   = 1'b0;
          err_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign CMD_READY   = (state == IDLE);
  assign BUSY        = (state != IDLE);
  assign ALU_IN_A    = a_q;
  assign ALU_IN_B    = b_q;
  assign ALU_Op_Code = op_q;
  assign RES_DATA    = res_q;
  assign RES_VALID   = vld_q;
  assign RES_ERR     = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed checks of alu_issue_ctrl at latency 1
// and latency 3, each instance driving a behavioural ALU.
module tb_alu_issue_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       cv1, cv3;
  logic       RES_READY;
  logic [3:0] CMD_OP;
  logic [7:0] CMD_A, CMD_B;

  logic       rdy1, rv1, re1, bz1;
  logic [7:0] ia1, ib1, out1, rd1;
  logic [3:0] op1;
  logic       rdy3, rv3, re3, bz3;
  logic [7:0] ia3, ib3, out3, rd3;
  logic [3:0] op3;

  int pass = 0;
  int total = 0;
  int cyc = 0;
  int acc_q[$];
  logic [7:0] res_q[$];

  always #5 CLK = ~CLK;

  function automatic logic [7:0] alu(input logic [3:0] op,
                                     input logic [7:0] a,
                                     input logic [7:0] b);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'hA: return {7'd0, a > b};
      4'hB: return {7'd0, a < b};
      default: return 8'h00;
    endcase
  endfunction

  assign out1 = alu(op1, ia1, ib1);
  assign out3 = alu(op3, ia3, ib3);

  alu_issue_ctrl #(.ALU_LATENCY(1)) u1 (
    .CLK(CLK), .RESET(RESET),
    .CMD_VALID(cv1), .CMD_READY(rdy1),
    .CMD_OP(CMD_OP), .CMD_A(CMD_A), .CMD_B(CMD_B),
    .ALU_IN_A(ia1), .ALU_IN_B(ib1), .ALU_Op_Code(op1),
    .ALU_Out(out1),
    .RES_VALID(rv1), .RES_READY(RES_READY),
    .RES_DATA(rd1), .RES_ERR(re1), .BUSY(bz1)
  );

  alu_issue_ctrl #(.ALU_LATENCY(3)) u3 (
    .CLK(CLK), .RESET(RESET),
    .CMD_VALID(cv3), .CMD_READY(rdy3),
    .CMD_OP(CMD_OP), .CMD_A(CMD_A), .CMD_B(CMD_B),
    .ALU_IN_A(ia3), .ALU_IN_B(ib3), .ALU_Op_Code(op3),
    .ALU_Out(out3),
    .RES_VALID(rv3), .RES_READY(RES_READY),
    .RES_DATA(rd3), .RES_ERR(re3), .BUSY(bz3)
  );

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (cv1 && rdy1) acc_q.push_back(cyc);
    if (rv1 && RES_READY) res_q.push_back(rd1);
  end

  task automatic chk(input string name, input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", name, got, exp);
    else
      pass++;
  endtask

  task automatic test_reset();
    RESET = 1'b1; cv1 = 0; cv3 = 0; RES_READY = 1;
    CMD_OP = 4'hF; CMD_A = 0; CMD_B = 0;
    @(negedge CLK);
    total++; if (rdy1 !== 1'b1) $display("FAIL rst_rdy: got %b expected 1", rdy1); else pass++;
    total++; if (op1 !== 4'hF) $display("FAIL rst_op: got %h expected f", op1); else pass++;
    total++; if ({ia1, ib1, rd1} !== 24'h0) $display("FAIL rst_data: got %h expected 0", {ia1, ib1, rd1}); else pass++;
    total++; if ({rv1, re1, bz1} !== 3'b000) $display("FAIL rst_flags: got %b expected 000", {rv1, re1, bz1}); else pass++;
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_add();
    RES_READY = 1;
    @(posedge CLK); #1;
    cv1 = 1; CMD_OP = 4'h0; CMD_A = 8'h05; CMD_B = 8'h03;
    @(posedge CLK); #1;
    cv1 = 0;
    @(negedge CLK);
    total++; if (op1 !== 4'h0) $display("FAIL add_op: got %h expected 0", op1); else pass++;
    total++; if ({ia1, ib1} !== 16'h0503) $display("FAIL add_opnd: got %h expected 0503", {ia1, ib1}); else pass++;
    total++; if ({rv1, rdy1, bz1} !== 3'b001) $display("FAIL add_wait: got %b expected 001", {rv1, rdy1, bz1}); else pass++;
    @(negedge CLK);
    total++; if ({rv1, re1} !== 2'b10) $display("FAIL add_resp: got %b expected 10", {rv1, re1}); else pass++;
    total++; if (rd1 !== 8'h08) $display("FAIL add_data: got %h expected 08", rd1); else pass++;
    total++; if (op1 !== 4'hF) $display("FAIL add_opnop: got %h expected f", op1); else pass++;
    total++; if (rdy1 !== 1'b0) $display("FAIL add_rdy_resp: got %b expected 0", rdy1); else pass++;
    @(negedge CLK);
    total++; if ({rv1, rdy1, bz1} !== 3'b010) $display("FAIL add_idle: got %b expected 010", {rv1, rdy1, bz1}); else pass++;
  endtask

  task automatic test_backpressure();
    RES_READY = 0;
    @(posedge CLK); #1;
    cv1 = 1; CMD_OP = 4'hA; CMD_A = 8'h06; CMD_B = 8'h05;
    @(posedge CLK); #1;
    cv1 = 0;
    @(posedge CLK);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      total++; if ({rv1, rdy1, bz1} !== 3'b101) $display("FAIL bp_flags%0d: got %b expected 101", i, {rv1, rdy1, bz1}); else pass++;
      total++; if (rd1 !== 8'h01) $display("FAIL bp_data%0d: got %h expected 01", i, rd1); else pass++;
      // Commands presented while not idle must be ignored.
      cv1 = 1; CMD_OP = 4'h0; CMD_A = 8'hFF; CMD_B = 8'h01;
      if (i < 2) @(posedge CLK);
    end
    cv1 = 0;
    RES_READY = 1;
    @(posedge CLK);
    @(negedge CLK);
    total++; if ({rv1, rdy1, bz1} !== 3'b010) $display("FAIL bp_release: got %b expected 010", {rv1, rdy1, bz1}); else pass++;
    total++; if (rd1 !== 8'h01) $display("FAIL bp_hold: got %h expected 01", rd1); else pass++;
  endtask

  task automatic test_latency3();
    RES_READY = 1;
    @(posedge CLK); #1;
    cv3 = 1; CMD_OP = 4'h1; CMD_A = 8'h05; CMD_B = 8'h03;
    @(posedge CLK); #1;
    cv3 = 0; CMD_OP = 4'h4; CMD_A = 8'hAA; CMD_B = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      total++; if ({op3, ia3, ib3} !== 20'h10503) $display("FAIL l3_hold%0d: got %h expected 10503", i, {op3, ia3, ib3}); else pass++;
      total++; if (rv3 !== 1'b0) $display("FAIL l3_early%0d: got %b expected 0", i, rv3); else pass++;
      @(posedge CLK);
    end
    @(negedge CLK);
    total++; if (rv3 !== 1'b1) $display("FAIL l3_rv: got %b expected 1", rv3); else pass++;
    total++; if (rd3 !== 8'h02) $display("FAIL l3_data: got %h expected 02", rd3); else pass++;
    total++; if (op3 !== 4'hF) $display("FAIL l3_opnop: got %h expected f", op3); else pass++;
    @(negedge CLK);
    total++; if ({rv3, rdy3} !== 2'b01) $display("FAIL l3_idle: got %b expected 01", {rv3, rdy3}); else pass++;
  endtask

  task automatic test_opcode_c();
    RES_READY = 1;
    @(posedge CLK); #1;
    cv1 = 1; CMD_OP = 4'hC; CMD_A = 8'h11; CMD_B = 8'h22;
    @(posedge CLK); #1;
    cv1 = 0;
    @(negedge CLK);
`ifdef ALU_ISSUE_OPCHECK_EN
    total++; if (op1 !== 4'hF) $display("FAIL opc_op: got %h expected f", op1); else pass++;
    total++; if ({rv1, re1} !== 2'b11) $display("FAIL opc_err: got %b expected 11", {rv1, re1}); else pass++;
    total++; if (rd1 !== 8'h00) $display("FAIL opc_data: got %h expected 00", rd1); else pass++;
`else
    total++; if (op1 !== 4'hC) $display("FAIL opc_op: got %h expected c", op1); else pass++;
    total++; if (rv1 !== 1'b0) $display("FAIL opc_wait: got %b expected 0", rv1); else pass++;
    @(negedge CLK);
    total++; if ({rv1, re1} !== 2'b10) $display("FAIL opc_resp: got %b expected 10", {rv1, re1}); else pass++;
`endif
    @(negedge CLK);
    total++; if ({rv1, re1, rdy1} !== 3'b001) $display("FAIL opc_idle: got %b expected 001", {rv1, re1, rdy1}); else pass++;
  endtask

  task automatic test_reset_wait();
    RES_READY = 1;
    @(posedge CLK); #1;
    cv1 = 1; CMD_OP = 4'h2; CMD_A = 8'h02; CMD_B = 8'h03;
    @(posedge CLK); #1;
    cv1 = 0;
    #2 RESET = 1'b1;
    #1;
    total++; if ({rdy1, bz1, rv1, re1} !== 4'b1000) $display("FAIL rw_flags: got %b expected 1000", {rdy1, bz1, rv1, re1}); else pass++;
    total++; if ({op1, ia1, ib1, rd1} !== 28'hF000000) $display("FAIL rw_data: got %h expected f000000", {op1, ia1, ib1, rd1}); else pass++;
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      total++; if (rv1 !== 1'b0) $display("FAIL rw_norv%0d: got %b expected 0", i, rv1); else pass++;
    end
  endtask

  task automatic test_back_to_back();
    int n;
    RES_READY = 1;
    acc_q.delete();
    res_q.delete();
    @(posedge CLK); #1;
    cv1 = 1; CMD_OP = 4'h0; CMD_A = 8'h10; CMD_B = 8'h20;
    @(posedge CLK); #1;
    CMD_OP = 4'h1; CMD_A = 8'h09; CMD_B = 8'h0C;
    n = 0;
    while (acc_q.size() < 2 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    cv1 = 0;
    n = 0;
    while (res_q.size() < 2 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    total++;
    if (acc_q.size() != 2) $display("FAIL b2b_accepts: got %0d expected 2", acc_q.size());
    else if (acc_q[1] - acc_q[0] != 3) $display("FAIL b2b_period: got %0d expected 3", acc_q[1] - acc_q[0]);
    else pass++;
    total++;
    if (res_q.size() != 2) $display("FAIL b2b_results: got %0d expected 2", res_q.size());
    else if ({res_q[0], res_q[1]} !== 16'h30FD) $display("FAIL b2b_order: got %h expected 30fd", {res_q[0], res_q[1]});
    else pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_backpressure();
    test_latency3();
    test_opcode_c();
    test_reset_wait();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
